replica_exchange_tx: RTL and testbench

Transmit side of the replica-exchange link. On an accepted `exchange_command_t` of PREV or FOLW, it reads one replica's city order from the local replica memory: `city_div` words of `replica_data_t`, 8 cities × 7 bits each. It streams those words to the neighbouring replica over a valid/ready beat interface, tagged with the direction. It sits between the per-replica order RAM and the inter-replica exchange fabric, whose receiver writes the beats into the neighbour's RAM.

---
 rtl/replica_pkg.sv | 40 ++++
 rtl/replica_tx_skid.sv | 53 +++++
 rtl/replica_exchange_tx.sv | 160 ++++++++++++++++
 tb/tb_replica_exchange_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// Shared types for the replica-exchange link: commands, order words, tour totals and link beats.
// Also holds the tx FSM state encoding.
package replica_pkg;

  localparam int unsigned city_num        = 30;
  localparam int unsigned city_bits       = 7;
  localparam int unsigned cities_per_word = 8;
  localparam int unsigned city_div        = (city_num + cities_per_word - 1) / cities_per_word;
  localparam int unsigned city_div_log    = (city_div > 1) ? $clog2(city_div) : 1;
  localparam int unsigned data_w          = city_bits * cities_per_word;
  localparam int unsigned total_w         = 23;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    SELF = 2'd1,
    PREV = 2'd2,
    FOLW = 2'd3
  } exchange_command_t;

  typedef logic [data_w-1:0]  replica_data_t;
  typedef logic [total_w-1:0] total_data_t;

  // One beat on the exchange fabric; the receiver uses the same layout.
  typedef struct packed {
    replica_data_t     data;
    exchange_command_t dir;
    logic              last;
  } exchange_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  function automatic logic is_transfer(exchange_command_t c);
    return (c == PREV) || (c == FOLW);
  endfunction

endpackage

// File: rtl/replica_tx_skid.sv
// Two-entry skid FIFO for outgoing exchange beats; the head is held in a register.
module replica_tx_skid
  import replica_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  exchange_beat_t push_beat,
  input  logic           pop,
  output logic           head_valid,
  output exchange_beat_t head_beat,
  output logic [1:0]     count
);

  exchange_beat_t slot0_q;
  exchange_beat_t slot1_q;
  logic [1:0]     count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= push_beat;
          else                 slot1_q <= push_beat;
          count_q <= 2'(count_q + 2'd1);
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= 2'(count_q - 2'd1);
        end
        2'b11: begin
          // Count unchanged: the new beat lands behind whatever remains.
          if (count_q == 2'd1) begin
            slot0_q <= push_beat;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_beat  = slot0_q;
  assign count      = count_q;

endmodule

// File: rtl/replica_exchange_tx.sv
// Streams one replica's city order from local RAM to a neighbour over a valid/ready link.
// Build option REPLICA_TX_CHECKSUM_EN appends an XOR checksum beat to every transfer.
module replica_exchange_tx
  import replica_pkg::*;
#(
  parameter int unsigned WORDS = city_div,
  parameter int unsigned AW    = city_div_log
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  exchange_command_t cmd,
  input  total_data_t       cmd_total,
  output logic              cmd_ready,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  replica_data_t     rd_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output replica_data_t     tx_data,
  output exchange_command_t tx_dir,
  output logic              tx_last,
  output total_data_t       tx_total,
  output logic              tx_done
);

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [AW-1:0]     rd_cnt_q;
  logic              resp_valid_q;
  logic              resp_last_q;
  exchange_command_t dir_q;
  total_data_t       total_q;
  logic              done_q;

  logic              accept;
  logic              xfer_accept;
  logic              pop;
  logic              push;
  logic              last_read;
  logic [2:0]        held_after_pop;
  exchange_beat_t    push_beat;
  exchange_beat_t    head_beat;
  logic              head_valid;
  logic [1:0]        fifo_count;

  assign accept      = cmd_valid && (state_q == ST_IDLE);
  assign xfer_accept = accept && is_transfer(cmd);
  assign pop         = head_valid && tx_ready;
  assign last_read   = (rd_cnt_q == AW'(WORDS - 1));
  // Words the FIFO must still absorb once this cycle's pop leaves; caps reads at two outstanding.
  assign held_after_pop = 3'(fifo_count) + 3'(resp_valid_q) - 3'(pop);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (xfer_accept) state_d = ST_READ;
      ST_READ:  if (rd_en && last_read) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && head_beat.last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_READ: rd_en     = (held_after_pop < 3'd2);
      default: ;
    endcase
  end

  // Read address, response tracking and per-transfer context.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      dir_q        <= NOP;
      total_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      resp_valid_q <= rd_en;
      resp_last_q  <= rd_en && last_read;
      done_q       <= (accept && (cmd == SELF)) ||
                      ((state_q == ST_DRAIN) && pop && head_beat.last);
      if (xfer_accept) begin
        rd_cnt_q <= '0;
        dir_q    <= cmd;
        total_q  <= cmd_total;
      end else if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + AW'(1);
      end
    end
  end

`ifdef REPLICA_TX_CHECKSUM_EN
  replica_data_t csum_q;
  logic          csum_pend_q;
  logic          csum_push;

  // The checksum slot takes a FIFO entry only after every data word has landed.
  assign csum_push = csum_pend_q && !resp_valid_q && (held_after_pop < 3'd2);
  assign push      = resp_valid_q || csum_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
    end else if (xfer_accept) begin
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
    end else begin
      if (resp_valid_q) csum_q <= csum_q ^ rd_data;
      if (resp_valid_q && resp_last_q) csum_pend_q <= 1'b1;
      else if (csum_push)              csum_pend_q <= 1'b0;
    end
  end

  always_comb begin
    push_beat.data = resp_valid_q ? rd_data : csum_q;
    push_beat.dir  = dir_q;
    push_beat.last = !resp_valid_q;
  end
`else
  assign push = resp_valid_q;

  always_comb begin
    push_beat.data = rd_data;
    push_beat.dir  = dir_q;
    push_beat.last = resp_last_q;
  end
`endif

  replica_tx_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_beat  (push_beat),
    .pop        (pop),
    .head_valid (head_valid),
    .head_beat  (head_beat),
    .count      (fifo_count)
  );

  assign rd_addr  = rd_cnt_q;
  assign tx_valid = head_valid;
  assign tx_data  = head_beat.data;
  assign tx_last  = head_valid && head_beat.last;
  assign tx_dir   = head_valid ? head_beat.dir : dir_q;
  assign tx_total = total_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_replica_exchange_tx.sv
// Directed self-checking bench for replica_exchange_tx with a one-cycle-latency RAM model.
module tb_replica_exchange_tx;
  import replica_pkg::*;

  localparam int unsigned WORDS = 4;
  localparam int unsigned AW    = 2;
`ifdef REPLICA_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  exchange_command_t cmd;
  total_data_t       cmd_total;
  logic              cmd_ready;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  replica_data_t     rd_data;
  logic              tx_valid;
  logic              tx_ready;
  replica_data_t     tx_data;
  exchange_command_t tx_dir;
  logic              tx_last;
  total_data_t       tx_total;
  logic              tx_done;

  replica_exchange_tx #(.WORDS(WORDS), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_total (cmd_total),
    .cmd_ready (cmd_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_dir    (tx_dir),
    .tx_last   (tx_last),
    .tx_total  (tx_total),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  replica_data_t mem [WORDS];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int total, bad;
  int cyc, nbeats, hs_cnt, issued, rden_cnt, valid_cnt, done_cnt, done_cyc;
  int first_valid, credit_viol, stable_viol, last_cnt, accepts, accept_cyc;
  logic done_ready, hold_prev, prev_last;
  replica_data_t prev_data;
  exchange_command_t prev_dir;
  replica_data_t     b_data  [16];
  logic              b_last  [16];
  exchange_command_t b_dir   [16];
  total_data_t       b_total [16];
  int                b_cyc   [16];

  function automatic replica_data_t exp_data(int i);
    replica_data_t x;
    x = '0;
    if (i < int'(WORDS)) return mem[2'(i)];
    for (int k = 0; k < int'(WORDS); k++) x = x ^ mem[2'(k)];
    return x;
  endfunction

  task automatic clear_mon();
    cyc = 0; nbeats = 0; hs_cnt = 0; issued = 0; rden_cnt = 0; valid_cnt = 0;
    done_cnt = 0; done_cyc = -1; first_valid = -1; credit_viol = 0; stable_viol = 0;
    last_cnt = 0; accepts = 0; accept_cyc = -1; done_ready = 1'b0; hold_prev = 1'b0;
  endtask

  // Sample one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (hold_prev && !(tx_valid && tx_data == prev_data && tx_last == prev_last && tx_dir == prev_dir))
      stable_viol++;
    hold_prev = tx_valid && !tx_ready;
    prev_data = tx_data; prev_last = tx_last; prev_dir = tx_dir;
    if (tx_valid && tx_ready) begin
      if (nbeats < 16) begin
        b_data[nbeats] = tx_data; b_last[nbeats] = tx_last; b_dir[nbeats] = tx_dir;
        b_total[nbeats] = tx_total; b_cyc[nbeats] = cyc;
      end
      nbeats++; hs_cnt++;
      if (tx_last) last_cnt++;
    end
    if (rd_en) begin
      if (issued - hs_cnt >= 2) credit_viol++;
      issued++; rden_cnt++;
    end
    if (tx_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (tx_done) begin done_cnt++; done_cyc = cyc; done_ready = cmd_ready; end
    if (cmd_valid && cmd_ready) begin accepts++; accept_cyc = cyc; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd = NOP; cmd_total = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b want=1", cmd_ready); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b want=0", rd_en); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid); end
    total++; if (tx_last !== 1'b0) begin bad++; $display("FAIL reset_tx_last got=%0b want=0", tx_last); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%0b want=0", tx_done); end
    total++; if (rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0h want=0", rd_addr); end
    total++; if (tx_data !== '0) begin bad++; $display("FAIL reset_tx_data got=%0h want=0", tx_data); end
    total++; if (tx_total !== '0) begin bad++; $display("FAIL reset_tx_total got=%0h want=0", tx_total); end
    total++; if (tx_dir !== NOP) begin bad++; $display("FAIL reset_tx_dir got=%0d want=%0d", tx_dir, NOP); end
    reset = 1'b0;
  endtask

  task automatic test_prev_stream();
    mem[0] = 56'h01; mem[1] = 56'h02; mem[2] = 56'h03; mem[3] = 56'h04;
    tx_ready = 1'b1;
    clear_mon();
    cmd_valid = 1'b1; cmd = PREV; cmd_total = 23'h12345;
    step();
    cmd_valid = 1'b0; cmd = NOP; cmd_total = '0;
    repeat (12) step();
    total++; if (first_valid !== 3) begin bad++; $display("FAIL prev_first_valid got=%0d want=3", first_valid); end
    total++; if (nbeats !== NB) begin bad++; $display("FAIL prev_beats got=%0d want=%0d", nbeats, NB); end
    for (int i = 0; i < NB; i++) begin
      total++; if (b_data[i] !== exp_data(i)) begin bad++; $display("FAIL prev_data[%0d] got=%0h want=%0h", i, b_data[i], exp_data(i)); end
      total++; if (b_last[i] !== (i == NB - 1)) begin bad++; $display("FAIL prev_last[%0d] got=%0b want=%0b", i, b_last[i], (i == NB - 1)); end
      total++; if (b_dir[i] !== PREV) begin bad++; $display("FAIL prev_dir[%0d] got=%0d want=%0d", i, b_dir[i], PREV); end
      total++; if (b_total[i] !== 23'h12345) begin bad++; $display("FAIL prev_total[%0d] got=%0h want=12345", i, b_total[i]); end
      total++; if (b_cyc[i] !== 3 + i) begin bad++; $display("FAIL prev_beat_cycle[%0d] got=%0d want=%0d", i, b_cyc[i], 3 + i); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL prev_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 3 + NB) begin bad++; $display("FAIL prev_done_cycle got=%0d want=%0d", done_cyc, 3 + NB); end
    total++; if (done_ready !== 1'b1) begin bad++; $display("FAIL prev_ready_at_done got=%0b want=1", done_ready); end
  endtask

  task automatic test_folw_backpressure();
    mem[0] = 56'h11; mem[1] = 56'h22; mem[2] = 56'h33; mem[3] = 56'h44;
    clear_mon();
    tx_ready = 1'b1;
    cmd_valid = 1'b1; cmd = FOLW; cmd_total = 23'h00abc;
    step();
    cmd_valid = 1'b0; cmd = NOP;
    repeat (24) begin
      tx_ready = ((cyc % 3) == 0);
      step();
    end
    tx_ready = 1'b1;
    total++; if (nbeats !== NB) begin bad++; $display("FAIL folw_beats got=%0d want=%0d", nbeats, NB); end
    for (int i = 0; i < NB; i++) begin
      total++; if (b_data[i] !== exp_data(i)) begin bad++; $display("FAIL folw_data[%0d] got=%0h want=%0h", i, b_data[i], exp_data(i)); end
      total++; if (b_dir[i] !== FOLW) begin bad++; $display("FAIL folw_dir[%0d] got=%0d want=%0d", i, b_dir[i], FOLW); end
    end
    total++; if (b_last[NB-1] !== 1'b1) begin bad++; $display("FAIL folw_last got=%0b want=1", b_last[NB-1]); end
    total++; if (last_cnt !== 1) begin bad++; $display("FAIL folw_last_count got=%0d want=1", last_cnt); end
    total++; if (credit_viol !== 0) begin bad++; $display("FAIL folw_credit got=%0d want=0", credit_viol); end
    total++; if (stable_viol !== 0) begin bad++; $display("FAIL folw_stable got=%0d want=0", stable_viol); end
    total++; if (rden_cnt !== int'(WORDS)) begin bad++; $display("FAIL folw_reads got=%0d want=%0d", rden_cnt, WORDS); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL folw_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_self_nop();
    clear_mon();
    tx_ready = 1'b1;
    cmd_valid = 1'b1; cmd = SELF;
    step();
    cmd = NOP;
    step();
    cmd_valid = 1'b0;
    repeat (6) step();
    total++; if (rden_cnt !== 0) begin bad++; $display("FAIL self_nop_reads got=%0d want=0", rden_cnt); end
    total++; if (valid_cnt !== 0) begin bad++; $display("FAIL self_nop_valid got=%0d want=0", valid_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL self_nop_done got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL self_done_cycle got=%0d want=1", done_cyc); end
    total++; if (accepts !== 2) begin bad++; $display("FAIL self_nop_accepts got=%0d want=2", accepts); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL self_nop_ready got=%0b want=1", cmd_ready); end
  endtask

  task automatic test_reset_abort();
    mem[0] = 56'h11; mem[1] = 56'h22; mem[2] = 56'h33; mem[3] = 56'h44;
    clear_mon();
    tx_ready = 1'b1;
    cmd_valid = 1'b1; cmd = FOLW; cmd_total = 23'h00555;
    step();
    cmd_valid = 1'b0; cmd = NOP;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL abort_tx_valid got=%0b want=0", tx_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_cmd_ready got=%0b want=1", cmd_ready); end
    repeat (10) step();
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    total++; if (last_cnt !== 0) begin bad++; $display("FAIL abort_last got=%0d want=0", last_cnt); end
    total++; if (nbeats !== 2) begin bad++; $display("FAIL abort_beats got=%0d want=2", nbeats); end
    mem[0] = 56'ha0; mem[1] = 56'ha1; mem[2] = 56'ha2; mem[3] = 56'ha3;
    clear_mon();
    cmd_valid = 1'b1; cmd = PREV; cmd_total = 23'h00042;
    step();
    cmd_valid = 1'b0; cmd = NOP;
    repeat (12) step();
    total++; if (nbeats !== NB) begin bad++; $display("FAIL after_abort_beats got=%0d want=%0d", nbeats, NB); end
    for (int i = 0; i < NB; i++) begin
      total++; if (b_data[i] !== exp_data(i)) begin bad++; $display("FAIL after_abort_data[%0d] got=%0h want=%0h", i, b_data[i], exp_data(i)); end
    end
    total++; if (b_total[0] !== 23'h00042) begin bad++; $display("FAIL after_abort_total got=%0h want=42", b_total[0]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL after_abort_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    mem[0] = 56'h5a; mem[1] = 56'h6b; mem[2] = 56'h7c; mem[3] = 56'h8d;
    clear_mon();
    tx_ready = 1'b1;
    cmd_valid = 1'b1; cmd = PREV; cmd_total = 23'h00100;
    step();
    cmd = FOLW; cmd_total = 23'h00777;
    repeat (30) begin
      step();
      if (accepts >= 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0; cmd = NOP;
    total++; if (accepts !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", accepts); end
    total++; if (accept_cyc !== 3 + NB) begin bad++; $display("FAIL b2b_accept_cycle got=%0d want=%0d", accept_cyc, 3 + NB); end
    total++; if (nbeats !== 2 * NB) begin bad++; $display("FAIL b2b_beats got=%0d want=%0d", nbeats, 2 * NB); end
    for (int i = 0; i < 2 * NB; i++) begin
      total++; if (b_data[i] !== exp_data(i % NB)) begin bad++; $display("FAIL b2b_data[%0d] got=%0h want=%0h", i, b_data[i], exp_data(i % NB)); end
    end
    total++; if (b_dir[NB-1] !== PREV) begin bad++; $display("FAIL b2b_dir_first got=%0d want=%0d", b_dir[NB-1], PREV); end
    total++; if (b_dir[NB] !== FOLW) begin bad++; $display("FAIL b2b_dir_second got=%0d want=%0d", b_dir[NB], FOLW); end
    total++; if (b_total[NB] !== 23'h00777) begin bad++; $display("FAIL b2b_total_second got=%0h want=777", b_total[NB]); end
    total++; if (done_cnt !== 2) begin bad++; $display("FAIL b2b_done got=%0d want=2", done_cnt); end
  endtask

`ifdef REPLICA_TX_CHECKSUM_EN
  task automatic test_checksum();
    mem[0] = 56'h0f; mem[1] = 56'hf0; mem[2] = 56'hff; mem[3] = 56'h01;
    clear_mon();
    tx_ready = 1'b1;
    cmd_valid = 1'b1; cmd = FOLW; cmd_total = 23'h00001;
    step();
    cmd_valid = 1'b0; cmd = NOP;
    repeat (14) step();
    total++; if (nbeats !== 5) begin bad++; $display("FAIL csum_beats got=%0d want=5", nbeats); end
    total++; if (b_data[4] !== 56'h01) begin bad++; $display("FAIL csum_value got=%0h want=1", b_data[4]); end
    total++; if (b_last[4] !== 1'b1) begin bad++; $display("FAIL csum_last got=%0b want=1", b_last[4]); end
    total++; if (b_last[3] !== 1'b0) begin bad++; $display("FAIL csum_data_last got=%0b want=0", b_last[3]); end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rd_data = '0;
    for (int k = 0; k < int'(WORDS); k++) mem[k] = '0;
    clear_mon();
    test_reset();
    test_prev_stream();
    test_folw_backpressure();
    test_self_nop();
    test_reset_abort();
    test_back_to_back();
`ifdef REPLICA_TX_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
